// File: rtl/qpu_event_timing_queue.sv
// Timed event queue: buffers timestamped events and releases each when the local counter reaches it.
// Optional feature macro: QPU_EVTQ_LATE_DROP_EN (drop late heads, count them on drop_cnt).
module qpu_event_timing_queue #(
    parameter int DEPTH      = 16,
    parameter int TIME_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   time_ena,
    output logic [TIME_WIDTH-1:0]  time_o,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [TIME_WIDTH-1:0]  in_time,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_late,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
`ifdef QPU_EVTQ_LATE_DROP_EN
    output logic [7:0]             drop_cnt,
`endif
    output logic                   late_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]           CNT_ONE   = 1;
    localparam logic [AW:0]           CNT_FULL  = DEPTH;
    localparam logic [AW-1:0]         PTR_ONE   = 1;
    localparam logic [TIME_WIDTH-1:0] TIME_ONE  = 1;

    logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
    logic [TIME_WIDTH-1:0] mem_time_q [DEPTH];

    logic [TIME_WIDTH-1:0] time_q, time_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_late_q, out_late_d;
    logic                  late_err_q, late_err_d;

    logic                  push;
    logic                  pop;
    logic                  emit;
    logic                  drop_head;
    logic [TIME_WIDTH-1:0] head_diff;
    logic                  head_late;
    logic                  head_due;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign in_ready = !full;
    assign level    = count_q;
    assign time_o   = time_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_late  = out_late_q;
    assign late_err  = late_err_q;

    // Signed distance from now to the head timestamp; negative means past due.
    assign head_diff = mem_time_q[rd_ptr_q] - time_q;
    assign head_late = head_diff[TIME_WIDTH-1];
    assign head_due  = (head_diff == '0) || head_late;

`ifdef QPU_EVTQ_LATE_DROP_EN
    assign drop_head = head_late;
`else
    assign drop_head = 1'b0;
`endif

    always_comb begin
        push        = in_valid && in_ready && !clr;
        pop         = !empty && head_due && !clr;
        emit        = pop && !drop_head;

        time_d      = time_ena ? (time_q + TIME_ONE) : time_q;
        wr_ptr_d    = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d    = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d     = count_q;
        out_valid_d = emit;
        out_data_d  = emit ? mem_data_q[rd_ptr_q] : out_data_q;
        out_late_d  = emit && head_late;
        late_err_d  = late_err_q || (pop && head_late);

        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        // Flush keeps the last released payload visible.
        if (clr) begin
            time_d     = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            late_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= in_data;
            mem_time_q[wr_ptr_q] <= in_time;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_late_q  <= 1'b0;
            late_err_q  <= 1'b0;
        end else begin
            time_q      <= time_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_late_q  <= out_late_d;
            late_err_q  <= late_err_d;
        end
    end

`ifdef QPU_EVTQ_LATE_DROP_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            drop_cnt_d = '0;
        end else if (pop && head_late && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule
